// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the scan-out path, the rasteriser and the
// video memory.
//   - 640x480@60 timing constants (default geometry)
//   - coord_t: pixel coordinate, COORD_W bits
//   - rgb444_t: 12-bit pixel word, R in [3:0], G in [7:4], B in [11:8]
//   - swap_state_t: front/back buffer swap handshake states
package vga_pkg;

   localparam int unsigned COORD_W = 11;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;
   localparam logic        VGA_SYNC_ACTIVE = 1'b0;

   // Packed MSB-first, so b lands in [11:8] and r in [3:0].
   typedef struct packed {
      logic [3:0] b;
      logic [3:0] g;
      logic [3:0] r;
   } rgb444_t;

   typedef enum logic {
      SWAP_IDLE    = 1'b0,
      SWAP_PENDING = 1'b1
   } swap_state_t;

   function automatic logic in_range(input coord_t c, input coord_t lo, input coord_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical scan counters and the raw (stage S0)
// timing flags derived from them. Everything advances only on pix_en.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   pix_en          pixel strobe
//   h_cnt, v_cnt    current scan position
//   active          position is inside the visible area
//   hs, vs          sync levels (SYNC_ACTIVE while in the sync window)
//   vblank          v_cnt >= V_ACTIVE
//   frame_origin    counters sit at (0,0) because they wrapped (not after reset)
//   vblank_start    this pix_en tick moves v_cnt to V_ACTIVE
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
   parameter int unsigned H_FP        = VGA_H_FP,
   parameter int unsigned H_SYNC      = VGA_H_SYNC,
   parameter int unsigned H_BP        = VGA_H_BP,
   parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
   parameter int unsigned V_FP        = VGA_V_FP,
   parameter int unsigned V_SYNC      = VGA_V_SYNC,
   parameter int unsigned V_BP        = VGA_V_BP,
   parameter logic        SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_en,
   output logic [COORD_W-1:0] h_cnt,
   output logic [COORD_W-1:0] v_cnt,
   output logic               active,
   output logic               hs,
   output logic               vs,
   output logic               vblank,
   output logic               frame_origin,
   output logic               vblank_start
);

   localparam coord_t HA        = coord_t'(H_ACTIVE);
   localparam coord_t H_SYNC_LO = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t H_SYNC_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t H_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam coord_t VA        = coord_t'(V_ACTIVE);
   localparam coord_t V_PRE     = coord_t'(V_ACTIVE - 1);
   localparam coord_t V_SYNC_LO = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t V_SYNC_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam coord_t V_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic h_last;
   logic v_last;
   logic wrapped;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt   <= '0;
         v_cnt   <= '0;
         wrapped <= 1'b0;
      end else if (pix_en) begin
         wrapped <= h_last && v_last;
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign active       = (h_cnt < HA) && (v_cnt < VA);
   assign hs           = in_range(h_cnt, H_SYNC_LO, H_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vs           = in_range(v_cnt, V_SYNC_LO, V_SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vblank       = (v_cnt >= VA);
   // The reset-time (0,0) is not a frame boundary; only a wrap is.
   assign frame_origin = wrapped;
   assign vblank_start = pix_en && h_last && (v_cnt == V_PRE);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA scan-out engine. Generates the timing, reads one RGB444
// word per visible pixel from video memory, blanks outside the visible area,
// drives registered colour/sync pins and hands buffers over from the
// rasteriser only at the start of vertical blanking.
// Pipeline in pix_en ticks: S0 counters -> S1 read request/memory data ->
// S2 pins (2 ticks from counter to pins, syncs delayed to match).
// Ports:
//   clk, rst_n, pix_en               clock, async active-low reset, pixel strobe
//   mem_rd_en/x/y/buf, mem_rd_data   video memory read port (data valid in S1)
//   swap_req, swap_ack               buffer swap handshake
//   vga_r/g/b, vga_hs, vga_vs        pins
//   vblank, frame_start              status, aligned with the pins
// Optional build macro VGA_SCANOUT_TEST_PATTERN_EN adds input test_mode,
// which replaces memory data with colour bars indexed by x[9:7] and
// suppresses memory reads.
//
// Swap FSM:
//   state        | meaning
//   SWAP_IDLE    | no swap requested
//   SWAP_PENDING | back buffer ready; swap at next vblank start if still requested
module vga_scanout
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
   parameter int unsigned H_FP        = VGA_H_FP,
   parameter int unsigned H_SYNC      = VGA_H_SYNC,
   parameter int unsigned H_BP        = VGA_H_BP,
   parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
   parameter int unsigned V_FP        = VGA_V_FP,
   parameter int unsigned V_SYNC      = VGA_V_SYNC,
   parameter int unsigned V_BP        = VGA_V_BP,
   parameter logic        SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_en,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   input  logic               test_mode,
`endif
   output logic               mem_rd_en,
   output logic [COORD_W-1:0] mem_rd_x,
   output logic [COORD_W-1:0] mem_rd_y,
   output logic               mem_rd_buf,
   input  logic [11:0]        mem_rd_data,
   input  logic               swap_req,
   output logic               swap_ack,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vblank,
   output logic               frame_start
);

   coord_t h_cnt, v_cnt;
   logic   t_active, t_hs, t_vs, t_vblank, t_origin, t_vb_start;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_ACTIVE(SYNC_ACTIVE)
   ) u_timing (
      .clk          (clk),
      .rst_n        (rst_n),
      .pix_en       (pix_en),
      .h_cnt        (h_cnt),
      .v_cnt        (v_cnt),
      .active       (t_active),
      .hs           (t_hs),
      .vs           (t_vs),
      .vblank       (t_vblank),
      .frame_origin (t_origin),
      .vblank_start (t_vb_start)
   );

   // S1: read request plus timing flags travelling alongside it
   logic act_d1, hs_d1, vs_d1, vb_d1, origin_d1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd_en <= 1'b0;
         mem_rd_x  <= '0;
         mem_rd_y  <= '0;
         act_d1    <= 1'b0;
         hs_d1     <= ~SYNC_ACTIVE;
         vs_d1     <= ~SYNC_ACTIVE;
         vb_d1     <= 1'b0;
         origin_d1 <= 1'b0;
      end else if (pix_en) begin
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
         mem_rd_en <= t_active && !test_mode;
`else
         mem_rd_en <= t_active;
`endif
         // Coordinates only move inside the visible area; the pattern
         // generator reuses them as its x.
         if (t_active) begin
            mem_rd_x <= h_cnt;
            mem_rd_y <= v_cnt;
         end
         act_d1    <= t_active;
         hs_d1     <= t_hs;
         vs_d1     <= t_vs;
         vb_d1     <= t_vblank;
         origin_d1 <= t_origin;
      end
   end

   // S2 colour select
   rgb444_t pix_next, pix_q;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   logic [2:0] bar_idx;
   assign bar_idx = mem_rd_x[9:7];
`endif

   always_comb begin
      pix_next = '0;
      if (act_d1) begin
         pix_next = rgb444_t'(mem_rd_data);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
         if (test_mode) begin
            pix_next.r = {4{bar_idx[0]}};
            pix_next.g = {4{bar_idx[1]}};
            pix_next.b = {4{bar_idx[2]}};
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q       <= '0;
         vga_hs      <= ~SYNC_ACTIVE;
         vga_vs      <= ~SYNC_ACTIVE;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_en && origin_d1;
         if (pix_en) begin
            pix_q  <= pix_next;
            vga_hs <= hs_d1;
            vga_vs <= vs_d1;
            vblank <= vb_d1;
         end
      end
   end

   assign vga_r = pix_q.r;
   assign vga_g = pix_q.g;
   assign vga_b = pix_q.b;

   // Swap FSM
   swap_state_t swap_state, swap_next;
   logic        do_swap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         swap_state <= SWAP_IDLE;
         mem_rd_buf <= 1'b0;
         swap_ack   <= 1'b0;
      end else begin
         swap_state <= swap_next;
         swap_ack   <= do_swap;
         if (do_swap) begin
            mem_rd_buf <= ~mem_rd_buf;
         end
      end
   end

   always_comb begin
      swap_next = swap_state;
      do_swap   = 1'b0;
      case (swap_state)
         SWAP_IDLE: begin
            if (swap_req) swap_next = SWAP_PENDING;
         end
         SWAP_PENDING: begin
            if (!swap_req) begin
               swap_next = SWAP_IDLE;
            end else if (t_vb_start) begin
               do_swap   = 1'b1;
               swap_next = SWAP_IDLE;
            end
         end
         default: swap_next = SWAP_IDLE;
      endcase
   end

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en = 1'b0;
   logic        swap_req = 1'b0;
   logic        mem_rd_en, mem_rd_buf, swap_ack;
   logic [10:0] mem_rd_x, mem_rd_y;
   logic [11:0] mem_rd_data;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vblank, frame_start;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   logic        test_mode = 1'b0;
`endif

   always #5 clk = ~clk;

   // Memory model: word {x,y,A}; garbage when not addressed so blanking is visible.
   assign mem_rd_data = mem_rd_en ? {mem_rd_x[3:0], mem_rd_y[3:0], 4'hA} : 12'hFFF;

   vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      .test_mode   (test_mode),
`endif
      .mem_rd_en   (mem_rd_en),
      .mem_rd_x    (mem_rd_x),
      .mem_rd_y    (mem_rd_y),
      .mem_rd_buf  (mem_rd_buf),
      .mem_rd_data (mem_rd_data),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vblank      (vblank),
      .frame_start (frame_start)
   );

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      logic        vb;
      logic        fs;
   } pin_t;

   pin_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   mh, mv;
   bit   wrapped;
   logic exp_buf;
   int   ack_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic pin_t expect_pins(input int h, input int v, input bit wr);
      pin_t       p;
      logic [3:0] hx, vy;
      hx    = 4'(h);
      vy    = 4'(v);
      p.rgb = (h < HA && v < VA) ? {hx, vy, 4'hA} : 12'h000;
      p.hs  = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
      p.vs  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
      p.vb  = (v >= VA);
      p.fs  = (h == 0 && v == 0 && wr);
      return p;
   endfunction

   function automatic pin_t reset_pins();
      pin_t p;
      p.rgb = 12'h000;
      p.hs  = 1'b1;
      p.vs  = 1'b1;
      p.vb  = 1'b0;
      p.fs  = 1'b0;
      return p;
   endfunction

   task automatic model_reset();
      mh      = 0;
      mv      = 0;
      wrapped = 0;
      exp_buf = 1'b0;
      exp_q.delete();
      exp_q.push_back(reset_pins());
   endtask

   // One pix_en tick followed by (div-1) idle clocks where everything must hold.
   task automatic step(input int div);
      pin_t e;
      bit   act, ack;
      logic req_before;
      exp_q.push_back(expect_pins(mh, mv, wrapped));
      act        = (mh < HA) && (mv < VA);
      req_before = swap_req;
      pix_en     = 1'b1;
      @(posedge clk);
      #1;
      pix_en = 1'b0;
      e = exp_q.pop_front();
      chk("rgb", {20'h0, vga_b, vga_g, vga_r}, {20'h0, e.rgb});
      chk("hs", vga_hs, e.hs);
      chk("vs", vga_vs, e.vs);
      chk("vblank", vblank, e.vb);
      chk("frame_start", frame_start, e.fs);
      chk("rd_en", mem_rd_en, act);
      if (act) begin
         chk("rd_x", mem_rd_x, mh);
         chk("rd_y", mem_rd_y, mv);
      end
      if (mh == HT - 1) begin
         mh = 0;
         if (mv == VT - 1) begin
            mv      = 0;
            wrapped = 1;
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
      ack = req_before && (mh == 0) && (mv == VA);
      if (ack) exp_buf = ~exp_buf;
      if (swap_ack) ack_seen++;
      chk("swap_ack", swap_ack, ack);
      chk("rd_buf", mem_rd_buf, exp_buf);
      if (ack) swap_req = 1'b0;
      repeat (div - 1) begin
         @(posedge clk);
         #1;
         chk("hold_rgb", {20'h0, vga_b, vga_g, vga_r}, {20'h0, e.rgb});
         chk("hold_hs", vga_hs, e.hs);
         chk("hold_vs", vga_vs, e.vs);
         chk("hold_vblank", vblank, e.vb);
         chk("hold_fs", frame_start, 1'b0);
         chk("hold_ack", swap_ack, 1'b0);
         chk("hold_rd_en", mem_rd_en, act);
         chk("hold_buf", mem_rd_buf, exp_buf);
      end
   endtask

   task automatic run_to(input int h, input int v, input int div);
      int n;
      n = 0;
      while (!(mh == h && mv == v) && n < 3000) begin
         step(div);
         n++;
      end
      chk("run_to_bound", (mh == h && mv == v), 1'b1);
   endtask

   initial begin
      int fs_cnt, fs_at;

      // Reset state
      model_reset();
      ack_seen = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rgb", {20'h0, vga_b, vga_g, vga_r}, 32'h0);
      chk("rst_hs", vga_hs, 1'b1);
      chk("rst_vs", vga_vs, 1'b1);
      chk("rst_vblank", vblank, 1'b0);
      chk("rst_fs", frame_start, 1'b0);
      chk("rst_rd_en", mem_rd_en, 1'b0);
      chk("rst_rd_x", mem_rd_x, 0);
      chk("rst_rd_y", mem_rd_y, 0);
      chk("rst_buf", mem_rd_buf, 1'b0);
      chk("rst_ack", swap_ack, 1'b0);
      #2 rst_n = 1'b1;

      // Full-rate scan; swap requested mid-frame lands at vblank start
      run_to(0, 3, 1);
      swap_req = 1'b1;
      run_to(0, 12, 1);
      // Request raised inside vblank waits for the next frame's vblank start
      swap_req = 1'b1;
      run_to(0, 11, 1);
      // Request withdrawn before vblank start: no swap
      run_to(0, 2, 1);
      swap_req = 1'b1;
      run_to(0, 5, 1);
      swap_req = 1'b0;
      run_to(0, 11, 1);
      chk("ack_count", ack_seen, 2);

      // Quarter-rate strobe: everything scales and holds between strobes
      run_to(0, 1, 4);
      swap_req = 1'b1;
      run_to(0, 12, 4);
      chk("ack_count_slow", ack_seen, 3);

      // Asynchronous reset mid-frame
      run_to(7, 5, 1);
      chk("buf_before_reset", mem_rd_buf, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rgb", {20'h0, vga_b, vga_g, vga_r}, 32'h0);
      chk("arst_hs", vga_hs, 1'b1);
      chk("arst_vs", vga_vs, 1'b1);
      chk("arst_vblank", vblank, 1'b0);
      chk("arst_rd_en", mem_rd_en, 1'b0);
      chk("arst_rd_x", mem_rd_x, 0);
      chk("arst_rd_y", mem_rd_y, 0);
      chk("arst_buf", mem_rd_buf, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();

      // First frame_start only after a complete frame from reset release
      fs_cnt = 0;
      fs_at  = 0;
      for (int k = 1; k <= HT * VT + 4; k++) begin
         step(1);
         if (frame_start) begin
            fs_cnt++;
            fs_at = k;
         end
      end
      chk("fs_count", fs_cnt, 1);
      chk("fs_tick", fs_at, HT * VT + 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
